// File: rtl/xosera_pkg.sv
// rtl/xosera_pkg.sv - shared types for the copper memory arbiter
package xosera_pkg;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DATA,
    RD_ACK
  } copmem_rd_state_t;

  localparam int COPMEM_STARVE_DEFAULT = 16;
endpackage

// File: rtl/copmem_arbiter_wr_arb.sv
// rtl/copmem_arbiter_wr_arb.sv - 2-way round-robin copper memory write arbiter
module copmem_wr_arb
  import xosera_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              host_wr_req_i,
  input  logic [AWIDTH-1:0] host_wr_addr_i,
  input  word_t             host_wr_data_i,
  output logic              host_wr_ack_o,
  input  logic              dma_wr_req_i,
  input  logic [AWIDTH-1:0] dma_wr_addr_i,
  input  word_t             dma_wr_data_i,
  output logic              dma_wr_ack_o,
  output logic              mem_wr_en_o,
  output logic [AWIDTH-1:0] mem_wr_addr_o,
  output word_t             mem_wr_data_o
);
  logic host_elig, dma_elig, grant_host, grant_dma;
  logic last_dma;

  // a requester being acked this cycle still holds req; mask it to avoid a repeat write
  always_comb begin
    host_elig  = host_wr_req_i && !host_wr_ack_o;
    dma_elig   = dma_wr_req_i && !dma_wr_ack_o;
    grant_host = host_elig && (!dma_elig || last_dma);
    grant_dma  = dma_elig && !grant_host;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      host_wr_ack_o <= 1'b0;
      dma_wr_ack_o  <= 1'b0;
      last_dma      <= 1'b1;
    end else begin
      mem_wr_en_o   <= grant_host || grant_dma;
      host_wr_ack_o <= grant_host;
      dma_wr_ack_o  <= grant_dma;
      if (grant_host) begin
        mem_wr_addr_o <= host_wr_addr_i;
        mem_wr_data_o <= host_wr_data_i;
        last_dma      <= 1'b0;
      end else if (grant_dma) begin
        mem_wr_addr_o <= dma_wr_addr_i;
        mem_wr_data_o <= dma_wr_data_i;
        last_dma      <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/copmem_arbiter.sv
// rtl/copmem_arbiter.sv - copper program memory arbiter (copper, host, DMA)
module copmem_arbiter
  import xosera_pkg::*;
#(
  parameter int AWIDTH       = 10,
  parameter int STARVE_LIMIT = COPMEM_STARVE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              cop_rd_en_i,
  input  logic [AWIDTH-1:0] cop_rd_addr_i,
  output logic              cop_stall_o,
  input  logic              host_rd_req_i,
  input  logic [AWIDTH-1:0] host_rd_addr_i,
  output word_t             host_rd_data_o,
  output logic              host_rd_ack_o,
  input  logic              host_wr_req_i,
  input  logic [AWIDTH-1:0] host_wr_addr_i,
  input  word_t             host_wr_data_i,
  output logic              host_wr_ack_o,
  input  logic              dma_wr_req_i,
  input  logic [AWIDTH-1:0] dma_wr_addr_i,
  input  word_t             dma_wr_data_i,
  output logic              dma_wr_ack_o,
  output logic [AWIDTH-1:0] mem_rd_addr_o,
  input  word_t             mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [AWIDTH-1:0] mem_wr_addr_o,
  output word_t             mem_wr_data_o
);
  copmem_rd_state_t rd_state, rd_next;
  logic [7:0]       starve_cnt;
  logic             host_grant, host_blocked;

  always_comb begin
    host_grant   = (rd_state == RD_IDLE) && host_rd_req_i && !cop_rd_en_i && !host_rd_ack_o;
    host_blocked = (rd_state == RD_IDLE) && host_rd_req_i && cop_rd_en_i;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) rd_state <= RD_IDLE;
    else         rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (host_grant) rd_next = RD_DATA;
      RD_DATA: rd_next = RD_ACK;
      RD_ACK:  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // copper always owns the read port when fetching; the port reads as zero while in reset
  always_comb begin
    host_rd_ack_o = (rd_state == RD_ACK);
    mem_rd_addr_o = '0;
    if (!reset_i) mem_rd_addr_o = cop_rd_en_i ? cop_rd_addr_i : host_rd_addr_i;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)                  host_rd_data_o <= '0;
    else if (rd_state == RD_DATA) host_rd_data_o <= mem_rd_data_i;
  end

  // stall is raised on the same edge the count reaches the limit and held until the grant
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      starve_cnt  <= '0;
      cop_stall_o <= 1'b0;
    end else if (host_grant) begin
      starve_cnt  <= '0;
      cop_stall_o <= 1'b0;
    end else if (host_blocked) begin
      if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      if (({1'b0, starve_cnt} + 9'd1) >= 9'(STARVE_LIMIT)) cop_stall_o <= 1'b1;
    end
  end

  copmem_wr_arb #(.AWIDTH(AWIDTH)) u_wr_arb (
    .clk           (clk),
    .reset_i       (reset_i),
    .host_wr_req_i (host_wr_req_i),
    .host_wr_addr_i(host_wr_addr_i),
    .host_wr_data_i(host_wr_data_i),
    .host_wr_ack_o (host_wr_ack_o),
    .dma_wr_req_i  (dma_wr_req_i),
    .dma_wr_addr_i (dma_wr_addr_i),
    .dma_wr_data_i (dma_wr_data_i),
    .dma_wr_ack_o  (dma_wr_ack_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o)
  );
endmodule

// File: doc/copmem_arbiter.md
Name: copmem_arbiter

Overview:
Sequences and shares the copper program memory (1 write port, 1 registered read port, 1-cycle read latency) between three clients. The copper execution engine fetches with absolute read priority. The host register interface (reads and writes) and the DMA/blit loader (writes only) compete for the remaining access. Sits between xosera_main client logic and the copper memory instance, in the single pixel-clock domain.

Parameters:
AWIDTH, 10, copper memory word-address width
STARVE_LIMIT, 16, cycles a blocked host read waits before copper is asked to stall (2..255)

Ports:
clk  input  1  system clock
reset_i  input  1  asynchronous active-high reset
cop_rd_en_i  input  1  copper fetch this cycle (always serviced)
cop_rd_addr_i  input  AWIDTH  copper fetch address
cop_stall_o  output  1  request copper to suspend fetches
host_rd_req_i  input  1  host read request, held until ack
host_rd_addr_i  input  AWIDTH  host read address, stable while req
host_rd_data_o  output  16  host read data (word_t), valid with ack, held after
host_rd_ack_o  output  1  one-cycle read completion pulse
host_wr_req_i  input  1  host write request, held until ack
host_wr_addr_i  input  AWIDTH  host write address
host_wr_data_i  input  16  host write data
host_wr_ack_o  output  1  one-cycle write-done pulse
dma_wr_req_i  input  1  DMA write request, held until ack
dma_wr_addr_i  input  AWIDTH  DMA write address
dma_wr_data_i  input  16  DMA write data
dma_wr_ack_o  output  1  one-cycle write-done pulse
mem_rd_addr_o  output  AWIDTH  to memory read address
mem_rd_data_i  input  16  from memory, valid cycle after address
mem_wr_en_o  output  1  memory write enable
mem_wr_addr_o  output  AWIDTH  memory write address
mem_wr_data_o  output  16  memory write data

Behaviour:
- Reset (async, any time, incl. mid-transaction): all outputs 0; read FSM IDLE; starvation counter 0; round-robin pointer favours host. In-flight requests are dropped, not acked; the requester must keep req asserted to be re-served.
- Read port mux (combinational): mem_rd_addr_o = cop_rd_en_i ? cop_rd_addr_i : host_rd_addr_i. Copper data is taken by the copper directly from mem_rd_data_i one cycle later; the arbiter never delays copper.
- Read FSM:
  - IDLE: if host_rd_req_i && !cop_rd_en_i && !host_rd_ack_o, the grant occurs this cycle (cycle N, host address on port) -> RD_DATA.
  - RD_DATA (N+1): register mem_rd_data_i into host_rd_data_o -> RD_ACK.
  - RD_ACK (N+2): host_rd_ack_o=1 for one cycle -> IDLE. host_req is ignored in the ack cycle.
  - Copper asserting cop_rd_en_i during RD_DATA/RD_ACK has no effect on the host read.
- Starvation: in IDLE, each cycle host_rd_req_i is high but blocked by cop_rd_en_i, the counter increments (saturating). When the count reaches STARVE_LIMIT, cop_stall_o is registered high. It stays high until the host grant cycle, then clears next cycle; the counter clears on grant. The copper may take any number of cycles to honour the stall; priority is unchanged.
- Write arbitration (registered):
  - Sample requests in cycle N. A requester whose ack is high in cycle N is masked.
  - If one eligible request, grant it. If both, grant the one opposite the pointer's last grant, then update the pointer.
  - Cycle N+1: mem_wr_en_o=1, addr/data from the winner, and the winner's ack pulses.
  - Max rate: one write/cycle alternating between the two requesters, one per 2 cycles for a single requester.
  - mem_wr_addr_o and mem_wr_data_o hold their last values when mem_wr_en_o=0.
- Read and write are independent. A same-address write/read in one cycle relies on the memory's write-forwarding; the arbiter adds no hazard logic.
- Widths: addresses pass through unmodified; no wrap or offset arithmetic.

Decomposition:
- xosera_pkg: word_t (existing); copmem_rd_state_t enum {RD_IDLE, RD_DATA, RD_ACK}; COPMEM_STARVE_DEFAULT localparam.
- One sub-module: copmem_wr_arb, the 2-way round-robin write arbiter with ack masking and registered write outputs. The read FSM and starvation counter stay in the top.

Test Plan:
- Reset mid-read: host read 0x050 granted, assert reset_i at RD_DATA -> all outputs 0 immediately, no ack. After release with req held, ack occurs 2 cycles after the new grant.
- Idle host read: memory[0x123]=0xBEEF, cop_rd_en_i=0, req at cycle 0 -> mem_rd_addr_o=0x123 at cycle 0, ack and data 0xBEEF at cycle 2, single-cycle ack.
- Copper priority: cop_rd_en_i held high, host req to 0x010 -> mem_rd_addr_o always tracks copper; cop_stall_o rises after 16 blocked cycles; copper drops en -> grant, ack 2 cycles later, stall clears the cycle after grant.
- Simultaneous writes: host (0x001,0x1111) and DMA (0x002,0x2222) both requested at reset release -> host written cycle 1, DMA cycle 2, one ack each, no duplicates.
- Continuous DMA stream of 8 writes (held req, new data after each ack) with host idle -> a write every 2nd cycle, all 8 values in memory in order.
- Write/read same address: host write 0x3C0=0xA5A5 while copper reads 0x3C0 the same cycle -> copper sees 0xA5A5 next cycle.
